// File: rtl/square_wave_generator.sv
// square_wave_generator
//   Turns an 8-bit half-period (in 48 kHz sample ticks) into a signed 16-bit
//   square-wave PCM stream, one sample per sample_tick. Period changes (note
//   change or key release) are only taken at half-cycle boundaries, so no
//   half-cycle is ever truncated.
//
//   Optional feature: define SQW_RAMP_EN for a linear attack/release envelope
//   (anti-click). Without it the level is a constant +/-AMPLITUDE.
//
// Ports
//   clk          in   system clock (I2S bit clock domain)
//   rst          in   asynchronous reset, active low
//   sample_tick  in   one-clk 48 kHz strobe
//   halfPeriod   in   [7:0] half-period in ticks, 0 = no key held
//   sample       out  [15:0] signed PCM sample, held between updates
//   sample_valid out  one-clk pulse, sample updated this cycle
//   active       out  1 while not IDLE
module square_wave_generator #(
  parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
  parameter logic        [15:0] RAMP_STEP = 16'd256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic [7:0]         halfPeriod,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               active
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0] state;
  logic [7:0] cnt;
  logic [7:0] hp_lat;
  logic       phase;

  // An IDLE tick with a key held is processed as the first RUN tick, so the
  // counters are viewed through these "effective" values.
  logic       starting;
  logic [7:0] eff_hp;
  logic [7:0] eff_cnt;
  logic       eff_phase;
  logic       boundary;
  logic signed [15:0] level;

  always_comb begin
    starting  = (state == IDLE);
    eff_hp    = starting ? halfPeriod : hp_lat;
    eff_cnt   = starting ? 8'd0 : cnt;
    eff_phase = starting ? 1'b1 : phase;
    boundary  = (eff_cnt == eff_hp - 8'd1);
  end

`ifdef SQW_RAMP_EN
  logic [15:0] env;
  logic [16:0] env_sum;
  logic [15:0] env_up;
  logic [15:0] env_dn;

  always_comb begin
    level   = env;
    env_sum = {1'b0, env} + {1'b0, RAMP_STEP};
    env_up  = (env_sum > {1'b0, AMPLITUDE}) ? AMPLITUDE : env_sum[15:0];
    env_dn  = (env > RAMP_STEP) ? (env - RAMP_STEP) : 16'd0;
  end
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
  assign level = AMPLITUDE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      phase        <= 1'b1;
      hp_lat       <= 8'd0;
      sample       <= '0;
      sample_valid <= 1'b0;
`ifdef SQW_RAMP_EN
      env          <= 16'd0;
`endif
    end else begin
      sample_valid <= sample_tick;
      if (sample_tick) begin
        if (starting && halfPeriod == 8'd0) begin
          sample <= '0;
        end else begin
          sample <= eff_phase ? level : -level;
          if (boundary) begin
            cnt   <= 8'd0;
            phase <= ~eff_phase;
            if (halfPeriod != 8'd0) begin
              hp_lat <= halfPeriod;
              state  <= RUN;
            end else begin
`ifdef SQW_RAMP_EN
              // Keep the last nonzero half-period so RELEASE keeps toggling.
              state  <= RELEASE;
`else
              hp_lat <= 8'd0;
              state  <= IDLE;
`endif
            end
          end else begin
            cnt    <= eff_cnt + 8'd1;
            phase  <= eff_phase;
            hp_lat <= eff_hp;
            if (starting) state <= RUN;
          end
`ifdef SQW_RAMP_EN
          if (state == RELEASE) begin
            env <= env_dn;
            // A new key at the boundary wins over the decay finishing.
            if (!(boundary && halfPeriod != 8'd0) && env_dn == 16'd0)
              state <= IDLE;
          end else begin
            env <= env_up;
          end
`endif
        end
      end
    end
  end

  assign active = (state != IDLE);

endmodule
